// File: rtl/uart_loader_pkg.sv
// Shared constants and command FSM state encoding for the UART boot loader.
package uart_loader_pkg;

    // Protocol bytes
    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] CMD_G   = 8'h47;
    localparam logic [7:0] ACK_OK  = 8'h2E;
    localparam logic [7:0] ACK_ERR = 8'h21;

    // UART register map and status bits
    localparam logic REG_DATA  = 1'b0;
    localparam logic REG_STAT  = 1'b1;
    localparam int   ST_TXFULL = 7;
    localparam int   ST_RXVAL  = 6;

    typedef enum logic [3:0] {
        S_IDLE, S_AH, S_AL, S_LEN, S_WDATA, S_WCHK, S_WACK, S_RDATA, S_RSEND, S_GO
    } cmd_state_e;

endpackage

// File: rtl/uart_loader_port.sv
// Byte-level sequencer on the UART register port: fetches one RX byte or
// sends one TX byte per request. rx_done_o / tx_done_o pulse for one cycle.
// Idle cycles keep reading the status register so the first poll after a
// request already sees a valid status value.
module uart_loader_port
    import uart_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_req_i,
    input  logic       tx_req_i,
    input  logic [7:0] tx_byte_i,
    input  logic [7:0] u_dbr_i,
    output logic       rx_done_o,
    output logic [7:0] rx_byte_o,
    output logic       tx_done_o,
    output logic       u_addr_o,
    output logic       u_we_o,
    output logic [7:0] u_dbw_o
);

    typedef enum logic [2:0] {
        P_IDLE, P_RXPOLL, P_RXRD, P_RXCAP, P_RXACK, P_TXPOLL, P_TXWR, P_TXGUARD
    } port_state_e;

    port_state_e state_q, state_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        guard_q, guard_d;
    logic        stat_ok_q;   // u_dbr_i currently holds a status read

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= P_IDLE;
            rx_byte_q <= '0;
            tx_byte_q <= '0;
            guard_q   <= 1'b0;
            stat_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_byte_q <= rx_byte_d;
            tx_byte_q <= tx_byte_d;
            guard_q   <= guard_d;
            stat_ok_q <= (u_addr_o == REG_STAT) && !u_we_o;
        end
    end

    // Next state and register-port drive; default is a status read
    always_comb begin
        state_d   = state_q;
        rx_byte_d = rx_byte_q;
        tx_byte_d = tx_byte_q;
        guard_d   = guard_q;
        u_addr_o  = REG_STAT;
        u_we_o    = 1'b0;
        u_dbw_o   = 8'h00;
        rx_done_o = 1'b0;
        tx_done_o = 1'b0;
        case (state_q)
            P_IDLE: begin
                if (tx_req_i) begin
                    tx_byte_d = tx_byte_i;
                    state_d   = P_TXPOLL;
                end else if (rx_req_i) begin
                    state_d = P_RXPOLL;
                end
            end
            P_RXPOLL: if (stat_ok_q && u_dbr_i[ST_RXVAL]) state_d = P_RXRD;
            P_RXRD: begin
                u_addr_o = REG_DATA;
                state_d  = P_RXCAP;
            end
            P_RXCAP: begin
                rx_byte_d = u_dbr_i;
                state_d   = P_RXACK;
            end
            P_RXACK: begin
                u_we_o    = 1'b1;
                rx_done_o = 1'b1;
                state_d   = P_IDLE;
            end
            P_TXPOLL: if (stat_ok_q && !u_dbr_i[ST_TXFULL]) state_d = P_TXWR;
            P_TXWR: begin
                u_addr_o = REG_DATA;
                u_we_o   = 1'b1;
                u_dbw_o  = tx_byte_q;
                guard_d  = 1'b0;
                state_d  = P_TXGUARD;
            end
            P_TXGUARD: begin
                // two cycles: the status read in flight may predate the write
                guard_d = 1'b1;
                if (guard_q) begin
                    tx_done_o = 1'b1;
                    state_d   = P_IDLE;
                end
            end
            default: state_d = P_IDLE;
        endcase
    end

    assign rx_byte_o = rx_byte_q;

endmodule

// File: rtl/uart_loader.sv
// Serial boot loader / monitor: decodes W (write), R (read) and G (go)
// commands from the UART and drives the memory bus while the CPU is held.
// Optional: UART_LOADER_CHECKSUM_EN adds a checksum byte to W commands.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              u_addr,
    output logic              u_we,
    output logic [7:0]        u_dbw,
    input  logic [7:0]        u_dbr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    output logic              cpu_hold,
    output logic              go,
    output logic [ADDR_W-1:0] go_addr,
    output logic              busy
);

    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    cmd_state_e        state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        ah_q, ah_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [7:0]        rdat_q, rdat_d;
    logic              rph_q, rph_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              run_q, run_d;     // CPU has been released by a Go
    logic              hold_q, hold_d;
    logic              go_q, go_d;
    logic [ADDR_W-1:0] go_addr_q, go_addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              err_q, err_d;
`endif

    logic       rx_req, tx_req, rx_done, tx_done;
    logic [7:0] rxb, tx_byte;
    logic       counting, expire;

    uart_loader_port u_port (
        .clk       (clk),
        .rst       (rst),
        .rx_req_i  (rx_req),
        .tx_req_i  (tx_req),
        .tx_byte_i (tx_byte),
        .u_dbr_i   (u_dbr),
        .rx_done_o (rx_done),
        .rx_byte_o (rxb),
        .tx_done_o (tx_done),
        .u_addr_o  (u_addr),
        .u_we_o    (u_we),
        .u_dbw_o   (u_dbw)
    );

    // The timer only runs while waiting on host bytes; once the last byte of
    // a W has arrived the ack is owed, and reads depend on TX pacing only.
    assign counting = state_q inside {S_AH, S_AL, S_LEN, S_WDATA, S_WCHK};
    assign expire   = (TIMEOUT_CYCLES != 0) && counting && !rx_done &&
                      (tmo_q == TW'(TLIM));

    // Command state and bus registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            ah_q        <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            rdat_q      <= '0;
            rph_q       <= 1'b0;
            tmo_q       <= '0;
            run_q       <= 1'b0;
            hold_q      <= 1'b1;
            go_q        <= 1'b0;
            go_addr_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            ah_q        <= ah_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            rdat_q      <= rdat_d;
            rph_q       <= rph_d;
            tmo_q       <= tmo_d;
            run_q       <= run_d;
            hold_q      <= hold_d;
            go_q        <= go_d;
            go_addr_q   <= go_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
            err_q       <= err_d;
`endif
        end
    end

    // Command decode, address/count sequencing, timeout abort
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        ah_d        = ah_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        rdat_d      = rdat_q;
        rph_d       = rph_q;
        run_d       = run_q;
        hold_d      = hold_q;
        go_d        = 1'b0;
        go_addr_d   = go_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        rx_req      = 1'b0;
        tx_req      = 1'b0;
        tx_byte     = ACK_OK;
        tmo_d       = (!counting || rx_done) ? '0 : tmo_q + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
        sum_d       = (rx_done && state_q != S_IDLE) ? sum_q + rxb : sum_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                rx_req = 1'b1;
                if (rx_done && (rxb == CMD_W || rxb == CMD_R || rxb == CMD_G)) begin
                    cmd_d   = rxb;
                    state_d = S_AH;
                    if (rxb != CMD_G) hold_d = 1'b1;
                end
            end
            S_AH: begin
                rx_req = 1'b1;
                if (rx_done) begin
                    ah_d    = rxb;
                    state_d = S_AL;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d   = rxb;
`endif
                end
            end
            S_AL: begin
                rx_req = 1'b1;
                if (rx_done) begin
                    addr_d  = ADDR_W'({ah_q, rxb});
                    state_d = (cmd_q == CMD_G) ? S_GO : S_LEN;
                end
            end
            S_LEN: begin
                rx_req = 1'b1;
                if (rx_done) begin
                    cnt_d = (rxb == 8'h00) ? 9'd256 : {1'b0, rxb};
                    if (cmd_q == CMD_W) begin
                        state_d = S_WDATA;
                    end else begin
                        mem_addr_d = addr_q;
                        rph_d      = 1'b0;
                        state_d    = S_RDATA;
                    end
                end
            end
            S_WDATA: begin
                rx_req = 1'b1;
                if (rx_done) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = rxb;
                    addr_d      = addr_q + 1'b1;
                    cnt_d       = cnt_q - 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                    if (cnt_q == 9'd1) state_d = S_WCHK;
`else
                    if (cnt_q == 9'd1) state_d = S_WACK;
`endif
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            S_WCHK: begin
                rx_req = 1'b1;
                if (rx_done) begin
                    err_d   = (sum_q + rxb) != 8'h00;
                    state_d = S_WACK;
                end
            end
`endif
            S_WACK: begin
                tx_req = 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
                tx_byte = err_q ? ACK_ERR : ACK_OK;
`endif
                if (tx_done) begin
                    state_d = S_IDLE;
                    hold_d  = ~run_q;
                end
            end
            S_RDATA: begin
                // first cycle presents the address, second captures the data
                rph_d = 1'b1;
                if (rph_q) begin
                    rdat_d  = mem_rdata;
                    state_d = S_RSEND;
                end
            end
            S_RSEND: begin
                tx_req  = 1'b1;
                tx_byte = rdat_q;
                if (tx_done) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == 9'd1) begin
                        state_d = S_IDLE;
                        hold_d  = ~run_q;
                    end else begin
                        mem_addr_d = addr_q + 1'b1;
                        rph_d      = 1'b0;
                        state_d    = S_RDATA;
                    end
                end
            end
            S_GO: begin
                go_d      = 1'b1;
                go_addr_d = addr_q;
                hold_d    = 1'b0;
                run_d     = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (expire) begin
            state_d = S_IDLE;
            hold_d  = ~run_q;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign cpu_hold  = hold_q;
    assign go        = go_q;
    assign go_addr   = go_addr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: a UART register model feeds host bytes and
// logs TX writes; a memory model logs writes. Checksum tests follow
// UART_LOADER_CHECKSUM_EN.
module tb_uart_loader;
    localparam int TO = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        u_addr, u_we, mem_we, cpu_hold, go, busy;
    logic [7:0]  u_dbw, mem_wdata;
    logic [7:0]  u_dbr = 8'h00;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] mem_addr, go_addr;

    always #5 clk = ~clk;

    uart_loader #(.ADDR_W(16), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .u_addr(u_addr), .u_we(u_we), .u_dbw(u_dbw),
        .u_dbr(u_dbr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .go(go), .go_addr(go_addr),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // UART model: host bytes are queued by the stimulus, TX writes are logged
    logic [7:0] host_q[$];
    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         rd_idx = 0, flush_tok = 0, seen_tok = 0, txfull = 0, txviol = 0, cyc = 0;
    logic       rxval = 1'b0;
    logic [7:0] rxdata = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!u_we) u_dbr <= u_addr ? {txfull != 0, rxval, 6'b0} : rxdata;
        if (flush_tok != seen_tok) begin
            seen_tok <= flush_tok;
            rd_idx   <= host_q.size();
            rxval    <= 1'b0;
        end else if (u_we && u_addr) begin
            rxval <= 1'b0;
        end else if (!rxval && rd_idx < host_q.size()) begin
            rxdata <= host_q[rd_idx];
            rxval  <= 1'b1;
            rd_idx <= rd_idx + 1;
        end
        if (u_we && !u_addr) begin
            tx_log.push_back(u_dbw);
            tx_cyc.push_back(cyc);
            if (txfull != 0) txviol <= txviol + 1;
            txfull <= 6;
        end else if (txfull != 0) begin
            txfull <= txfull - 1;
        end
    end

    // Memory model: img is preloaded by the stimulus, DUT writes go to wmem
    logic [7:0]  img  [0:65535];
    logic [7:0]  wmem [0:65535];
    logic        wvld [0:65535] = '{default: 1'b0};
    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    logic        wr_h[$];

    always @(posedge clk) begin
        mem_rdata <= wvld[mem_addr] ? wmem[mem_addr] : img[mem_addr];
        if (mem_we) begin
            wmem[mem_addr] <= mem_wdata;
            wvld[mem_addr] <= 1'b1;
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
            wr_h.push_back(cpu_hold);
        end
    end

    // Go pulse monitor
    int   go_cnt = 0;
    logic go_hold = 1'b1, go_hold_before = 1'b0, hold_prev = 1'b1;
    always @(posedge clk) begin
        hold_prev <= cpu_hold;
        if (go) begin
            go_cnt         <= go_cnt + 1;
            go_hold        <= cpu_hold;
            go_hold_before <= hold_prev;
        end
    end

    int tx_base = 0, wr_base = 0, go_base = 0;
    bit ok;

    task automatic mark();
        tx_base = tx_log.size();
        wr_base = wr_a.size();
        go_base = go_cnt;
    endtask

    task automatic send(input logic [7:0] b);
        host_q.push_back(b);
    endtask

    task automatic wait_tx(input int n, input int bound, output bit done);
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (tx_log.size() - tx_base >= n) done = 1'b1;
        end
    endtask

    task automatic wait_idle(input int bound, output bit done);
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && rd_idx == host_q.size() && !rxval) done = 1'b1;
        end
    endtask

    function automatic logic [7:0] txb(input int i);
        return (tx_base + i < tx_log.size()) ? tx_log[tx_base + i] : 8'hxx;
    endfunction

    function automatic logic [24:0] wrent(input int i);
        return (wr_base + i < wr_a.size()) ? {wr_h[wr_base + i], wr_a[wr_base + i], wr_d[wr_base + i]} : 25'hx;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({u_addr, u_we, u_dbw} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_uart got %b/%b/%h want 1/0/00", u_addr, u_we, u_dbw);
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_we} !== {16'h0000, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_mem got %h/%h/%b want 0000/00/0", mem_addr, mem_wdata, mem_we);
        end
        checks++;
        if ({cpu_hold, go, go_addr, busy} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctl got hold=%b go=%b go_addr=%h busy=%b want 1 0 0000 0",
                     cpu_hold, go, go_addr, busy);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        logic [24:0] exp [3];
        exp = '{{1'b1, 16'h1234, 8'hAA}, {1'b1, 16'h1235, 8'hBB}, {1'b1, 16'h1236, 8'hCC}};
        mark();
        send(8'h57); send(8'h12); send(8'h34); send(8'h03);
        send(8'hAA); send(8'hBB); send(8'hCC);
`ifdef UART_LOADER_CHECKSUM_EN
        send(8'h86);  // 12+34+03+AA+BB+CC = 7A, so 86 brings the total to 00
`endif
        wait_tx(1, 3000, ok);
        wait_idle(200, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (wr_a.size() - wr_base != 3) begin
            errors++;
            $display("FAIL write_count got %0d want 3", wr_a.size() - wr_base);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wrent(i) !== exp[i]) begin
                errors++;
                $display("FAIL write_entry%0d got %h want %h", i, wrent(i), exp[i]);
            end
        end
        checks++;
        if (tx_log.size() - tx_base != 1 || txb(0) !== 8'h2E) begin
            errors++;
            $display("FAIL write_ack got n=%0d b=%h want n=1 b=2e", tx_log.size() - tx_base, txb(0));
        end
        checks++;
        if (busy !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL write_end got busy=%b hold=%b want 0 1", busy, cpu_hold);
        end
    endtask

    task automatic test_read();
        logic [7:0] exp [3];
        exp = '{8'hAA, 8'hBB, 8'hCC};
        img[16'h1234] = 8'hAA; img[16'h1235] = 8'hBB; img[16'h1236] = 8'hCC;
        mark();
        send(8'h52); send(8'h12); send(8'h34); send(8'h03);
        wait_tx(3, 3000, ok);
        wait_idle(200, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (tx_log.size() - tx_base != 3) begin
            errors++;
            $display("FAIL read_count got %0d want 3", tx_log.size() - tx_base);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (txb(i) !== exp[i]) begin
                errors++;
                $display("FAIL read_byte%0d got %h want %h", i, txb(i), exp[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (tx_base + i >= tx_cyc.size() || tx_cyc[tx_base + i] - tx_cyc[tx_base + i - 1] < 3) begin
                errors++;
                $display("FAIL read_gap%0d got too short want >=3 cycles", i);
            end
        end
        checks++;
        if (txviol != 0 || wr_a.size() != wr_base) begin
            errors++;
            $display("FAIL read_side got txviol=%0d writes=%0d want 0 0", txviol, wr_a.size() - wr_base);
        end
    endtask

    task automatic test_wrap();
        img[16'hFFFF] = 8'h5A; img[16'h0000] = 8'hA5;
        mark();
        send(8'h52); send(8'hFF); send(8'hFF); send(8'h02);
        wait_tx(2, 3000, ok);
        wait_idle(200, ok);
        checks++;
        if (tx_log.size() - tx_base != 2 || txb(0) !== 8'h5A || txb(1) !== 8'hA5) begin
            errors++;
            $display("FAIL wrap got n=%0d %h %h want 2 5a a5", tx_log.size() - tx_base, txb(0), txb(1));
        end
    endtask

    task automatic test_len0();
        int bad;
        for (int i = 0; i < 256; i++) img[16'h0100 + i] = 8'(i) ^ 8'h3C;
        mark();
        send(8'h52); send(8'h01); send(8'h00); send(8'h00);
        wait_tx(256, 20000, ok);
        wait_idle(200, ok);
        repeat (40) @(negedge clk);
        checks++;
        if (tx_log.size() - tx_base != 256) begin
            errors++;
            $display("FAIL len0_count got %0d want 256", tx_log.size() - tx_base);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (txb(i) !== (8'(i) ^ 8'h3C)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL len0_data got %0d wrong bytes want 0", bad);
        end
    endtask

    task automatic test_timeout();
        mark();
        send(8'h57); send(8'h00); send(8'h10);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (rd_idx == host_q.size() && !rxval) ok = 1'b1;
        end
        repeat (TO / 2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early got busy=%b want 1", busy);
        end
        repeat (TO / 2 + 60) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_log.size() != tx_base || wr_a.size() != wr_base) begin
            errors++;
            $display("FAIL timeout_abort got busy=%b tx=%0d wr=%0d want 0 0 0",
                     busy, tx_log.size() - tx_base, wr_a.size() - wr_base);
        end
        img[16'h0010] = 8'h77;
        send(8'h52); send(8'h00); send(8'h10); send(8'h01);
        wait_tx(1, 3000, ok);
        wait_idle(200, ok);
        checks++;
        if (tx_log.size() - tx_base != 1 || txb(0) !== 8'h77) begin
            errors++;
            $display("FAIL timeout_next got n=%0d %h want 1 77", tx_log.size() - tx_base, txb(0));
        end
    endtask

    task automatic test_go();
        mark();
        send(8'h41);
        send(8'h47); send(8'h80); send(8'h00);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (go_cnt != go_base) ok = 1'b1;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (go_cnt - go_base != 1 || go_addr !== 16'h8000) begin
            errors++;
            $display("FAIL go_pulse got cycles=%0d addr=%h want 1 8000", go_cnt - go_base, go_addr);
        end
        checks++;
        if (go_hold_before !== 1'b1 || go_hold !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL go_hold got before=%b at=%b now=%b want 1 0 0", go_hold_before, go_hold, cpu_hold);
        end
        checks++;
        if (tx_log.size() != tx_base || wr_a.size() != wr_base || busy !== 1'b0) begin
            errors++;
            $display("FAIL go_stray got tx=%0d wr=%0d busy=%b want 0 0 0",
                     tx_log.size() - tx_base, wr_a.size() - wr_base, busy);
        end
    endtask

    task automatic test_hold_reassert();
        mark();
        send(8'h57); send(8'h20); send(8'h00); send(8'h01); send(8'h11);
`ifdef UART_LOADER_CHECKSUM_EN
        send(8'hCE);  // 20+00+01+11 = 32
`endif
        wait_tx(1, 3000, ok);
        wait_idle(200, ok);
        checks++;
        if (wrent(0) !== {1'b1, 16'h2000, 8'h11}) begin
            errors++;
            $display("FAIL hold_write got %h want 1_2000_11", wrent(0));
        end
        checks++;
        if (cpu_hold !== 1'b0 || txb(0) !== 8'h2E) begin
            errors++;
            $display("FAIL hold_release got hold=%b ack=%h want 0 2e", cpu_hold, txb(0));
        end
    endtask

`ifdef UART_LOADER_CHECKSUM_EN
    task automatic test_checksum_bad();
        mark();
        send(8'h57); send(8'h30); send(8'h00); send(8'h01); send(8'h55); send(8'h00);
        wait_tx(1, 3000, ok);
        wait_idle(200, ok);
        checks++;
        if (txb(0) !== 8'h21 || wrent(0) !== {1'b0, 16'h3000, 8'h55}) begin
            errors++;
            $display("FAIL cksum_bad got ack=%h wr=%h want 21 0_3000_55", txb(0), wrent(0));
        end
    endtask
`endif

    task automatic test_rst_mid();
        mark();
        send(8'h57); send(8'h40); send(8'h00); send(8'h04); send(8'h01); send(8'h02);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (mem_we === 1'b1 && mem_addr === 16'h4001) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_reach got no write to 4001 want one");
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({cpu_hold, u_we, mem_we, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_mid got hold=%b u_we=%b mem_we=%b busy=%b want 1 0 0 0",
                     cpu_hold, u_we, mem_we, busy);
        end
        flush_tok++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_log.size() != tx_base || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_after got busy=%b tx=%0d hold=%b want 0 0 1",
                     busy, tx_log.size() - tx_base, cpu_hold);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_len0();
        test_timeout();
        test_go();
        test_hold_reassert();
`ifdef UART_LOADER_CHECKSUM_EN
        test_checksum_bad();
`endif
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
